// File: rtl/apb_fabric_n.sv
// apb_fabric_n: registered APB interconnect, one core requester to TGT_N
// completers selected through a base/mask address map. Each core transfer is
// captured and re-issued as a fresh SETUP/ACCESS on the chosen target port.
// Unmapped addresses complete with an error response.
// Optional feature macro: APB_FABRIC_TIMEOUT_EN (ACCESS-phase watchdog).
`timescale 1ns/1ps
module apb_fabric_n #(
  parameter int                  TGT_N    = 2,
  parameter logic [TGT_N*32-1:0] TGT_BASE = {32'h8000_0000, 32'h0000_0000},
  parameter logic [TGT_N*32-1:0] TGT_MASK = {32'hFFFF_F000, 32'h8000_0000},
  parameter int                  TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_i_psel,
  input  logic                core_i_penable,
  input  logic                core_i_pwrite,
  input  logic [31:0]         core_i_paddr,
  input  logic [31:0]         core_i_pwdata,
  input  logic [3:0]          core_i_pwstrb,
  output logic                core_i_pready,
  output logic                core_i_pslverr,
  output logic [31:0]         core_i_prdata,
  output logic [TGT_N-1:0]    tgt_t_psel,
  output logic                tgt_t_penable,
  output logic                tgt_t_pwrite,
  output logic [31:0]         tgt_t_paddr,
  output logic [31:0]         tgt_t_pwdata,
  output logic [3:0]          tgt_t_pwstrb,
  input  logic [TGT_N-1:0]    tgt_t_pready,
  input  logic [TGT_N-1:0]    tgt_t_pslverr,
  input  logic [TGT_N*32-1:0] tgt_t_prdata
);

  localparam int IDX_W = (TGT_N > 1) ? $clog2(TGT_N) : 1;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("apb_fabric_n: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [31:0]        hit_mask;
  logic [IDX_W-1:0]   idx;
  logic               sel_ready;
  logic               sel_slverr;
  logic [31:0]        sel_rdata;
  logic               capture;
  logic               complete;
  logic               abort;
  logic               to_hit;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mask = '0;
    for (int i = TGT_N - 1; i >= 0; i--) begin
      if ((core_i_paddr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_mask = TGT_MASK[32*i +: 32];
      end
    end
  end

  // Response mux for the currently selected target.
  always_comb begin
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < TGT_N; i++) begin
      if (IDX_W'(i) == idx) begin
        sel_ready  = tgt_t_pready[i];
        sel_slverr = tgt_t_pslverr[i];
        sel_rdata  = tgt_t_prdata[32*i +: 32];
      end
    end
  end

`ifdef APB_FABRIC_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] to_cnt;

  // Watchdog: count non-ready ACCESS cycles, cleared while entering ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !sel_ready) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  assign to_hit = (state == ACCESS) && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and per-cycle control strobes; target ready beats the watchdog.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (core_i_psel && !core_i_penable) begin
          capture   = 1'b1;
          state_nxt = hit ? SETUP : RESP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          complete  = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, target-side sequencing and registered core response.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      tgt_t_psel     <= '0;
      tgt_t_penable  <= 1'b0;
      tgt_t_pwrite   <= 1'b0;
      tgt_t_paddr    <= '0;
      tgt_t_pwdata   <= '0;
      tgt_t_pwstrb   <= '0;
      core_i_pready  <= 1'b0;
      core_i_prdata  <= '0;
      core_i_pslverr <= 1'b0;
    end else begin
      core_i_pready <= 1'b0;
      if (capture) begin
        idx          <= hit_idx;
        tgt_t_paddr  <= core_i_paddr & ~hit_mask;
        tgt_t_pwrite <= core_i_pwrite;
        tgt_t_pwdata <= core_i_pwdata;
        tgt_t_pwstrb <= core_i_pwstrb;
        if (hit) begin
          tgt_t_psel <= TGT_N'(1) << hit_idx;
        end else begin
          core_i_pready  <= 1'b1;
          core_i_prdata  <= '0;
          core_i_pslverr <= 1'b1;
        end
      end
      if (state == SETUP) tgt_t_penable <= 1'b1;
      if (complete || abort) begin
        tgt_t_psel     <= '0;
        tgt_t_penable  <= 1'b0;
        core_i_pready  <= 1'b1;
        core_i_prdata  <= complete ? sel_rdata : 32'd0;
        core_i_pslverr <= complete ? sel_slverr : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_fabric_n.sv
// tb_apb_fabric_n: randomized and directed transfers against a behavioural
// model of the address map, per-target wait states and response latency.
`timescale 1ns/1ps
module tb_apb_fabric_n;

  localparam int TO = 4;
  localparam logic [31:0] BASE [2] = '{32'h0000_0000, 32'h8000_0000};
  localparam logic [31:0] MASK [2] = '{32'h8000_0000, 32'hFFFF_F000};

  logic        clk = 1'b0;
  logic        rst;
  logic        core_psel, core_penable, core_pwrite;
  logic [31:0] core_paddr, core_pwdata;
  logic [3:0]  core_pwstrb;
  logic        core_pready, core_pslverr;
  logic [31:0] core_prdata;
  logic [1:0]  tgt_psel;
  logic        tgt_penable, tgt_pwrite;
  logic [31:0] tgt_paddr, tgt_pwdata;
  logic [3:0]  tgt_pwstrb;
  logic [1:0]  tgt_pready, tgt_pslverr;
  logic [63:0] tgt_prdata;

  logic [31:0] t_rdata [2];
  logic        t_err   [2];
  int          t_waits [2];
  int          wcnt    [2];

  int vec_cnt = 0;
  int err_cnt = 0;

  apb_fabric_n #(
    .TGT_N   (2),
    .TGT_BASE({32'h8000_0000, 32'h0000_0000}),
    .TGT_MASK({32'hFFFF_F000, 32'h8000_0000}),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_i_psel   (core_psel),
    .core_i_penable(core_penable),
    .core_i_pwrite (core_pwrite),
    .core_i_paddr  (core_paddr),
    .core_i_pwdata (core_pwdata),
    .core_i_pwstrb (core_pwstrb),
    .core_i_pready (core_pready),
    .core_i_pslverr(core_pslverr),
    .core_i_prdata (core_prdata),
    .tgt_t_psel    (tgt_psel),
    .tgt_t_penable (tgt_penable),
    .tgt_t_pwrite  (tgt_pwrite),
    .tgt_t_paddr   (tgt_paddr),
    .tgt_t_pwdata  (tgt_pwdata),
    .tgt_t_pwstrb  (tgt_pwstrb),
    .tgt_t_pready  (tgt_pready),
    .tgt_t_pslverr (tgt_pslverr),
    .tgt_t_prdata  (tgt_prdata)
  );

  always #5 clk = ~clk;

  // Completer models: ready after t_waits ACCESS cycles.
  always_comb begin
    tgt_pready  = '0;
    tgt_pslverr = '0;
    tgt_prdata  = '0;
    for (int i = 0; i < 2; i++) begin
      tgt_pready[i]         = tgt_psel[i] && tgt_penable && (wcnt[i] >= t_waits[i]);
      tgt_pslverr[i]        = t_err[i];
      tgt_prdata[32*i +: 32] = t_rdata[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tgt_psel[i] && tgt_penable && !tgt_pready[i]) wcnt[i] <= wcnt[i] + 1;
      else                                              wcnt[i] <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_pready"},  32'(core_pready), 0);
    chk({pfx, "_prdata"},  core_prdata, 0);
    chk({pfx, "_pslverr"}, 32'(core_pslverr), 0);
    chk({pfx, "_tpsel"},   32'(tgt_psel), 0);
    chk({pfx, "_tpen"},    32'(tgt_penable), 0);
    chk({pfx, "_tpaddr"},  tgt_paddr, 0);
    chk({pfx, "_tpwrite"}, 32'(tgt_pwrite), 0);
    chk({pfx, "_tpwdata"}, tgt_pwdata, 0);
    chk({pfx, "_tpwstrb"}, 32'(tgt_pwstrb), 0);
  endtask

  // One core transfer; expectations come from the address map and target setup.
  task automatic do_xfer(input logic [31:0] a, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st);
    int          tgt, n, exp_lat;
    logic [31:0] exp_rd;
    logic        exp_err;
    tgt = decode(a);
    if (tgt < 0) begin
      exp_lat = 1; exp_rd = 0; exp_err = 1'b1;
    end else begin
      exp_lat = 3 + t_waits[tgt]; exp_rd = t_rdata[tgt]; exp_err = t_err[tgt];
`ifdef APB_FABRIC_TIMEOUT_EN
      if (t_waits[tgt] >= TO) begin
        exp_lat = 2 + TO; exp_rd = 0; exp_err = 1'b1;
      end
`endif
    end
    @(posedge clk); #1;
    core_psel = 1'b1; core_penable = 1'b0; core_pwrite = wr;
    core_paddr = a; core_pwdata = wd; core_pwstrb = st;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        core_penable = 1'b1;
        if (tgt < 0) begin
          chk("miss_psel", 32'(tgt_psel), 0);
        end else begin
          chk("setup_psel", 32'(tgt_psel), 32'(1 << tgt));
          chk("setup_penable", 32'(tgt_penable), 0);
          chk("setup_paddr", tgt_paddr, a & ~MASK[tgt]);
          chk("setup_pwrite", 32'(tgt_pwrite), 32'(wr));
          chk("early_pready", 32'(core_pready), 0);
          if (wr) begin
            chk("setup_pwdata", tgt_pwdata, wd);
            chk("setup_pwstrb", 32'(tgt_pwstrb), 32'(st));
          end
        end
      end else if (n == 2 && tgt >= 0) begin
        chk("access_psel", 32'(tgt_psel), 32'(1 << tgt));
        chk("access_penable", 32'(tgt_penable), 1);
      end
    end while (!core_pready && n < exp_lat + 20);
    chk("latency", n, exp_lat);
    chk("prdata", core_prdata, exp_rd);
    chk("pslverr", 32'(core_pslverr), 32'(exp_err));
    chk("resp_psel", 32'(tgt_psel), 0);
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    core_psel = 1'b0; core_penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    rst = 1'b1;
    core_psel = 0; core_penable = 0; core_pwrite = 0;
    core_paddr = 0; core_pwdata = 0; core_pwstrb = 0;
    for (int i = 0; i < 2; i++) begin
      t_rdata[i] = 0; t_err[i] = 0; t_waits[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Zero-wait read from target 0.
    t_rdata[0] = 32'hDEAD_BEEF; t_err[0] = 0; t_waits[0] = 0;
    do_xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    idle_gap();

    // Write to target 1 with three wait states.
    t_rdata[1] = 32'h1234_5678; t_err[1] = 0; t_waits[1] = 3;
    do_xfer(32'h8000_0004, 1'b1, 32'h0000_0055, 4'b0001);

    // Unmapped address, back-to-back.
    do_xfer(32'h9000_0000, 1'b0, 32'h0, 4'h0);

    // Error from target 0 then a clean back-to-back read from target 1.
    t_err[0] = 1; t_rdata[0] = 32'hA5A5_0001;
    t_waits[1] = 0; t_rdata[1] = 32'hCAFE_F00D;
    do_xfer(32'h0000_0200, 1'b0, 32'h0, 4'h0);
    do_xfer(32'h8000_0008, 1'b0, 32'h0, 4'h0);
    t_err[0] = 0;
    idle_gap();

`ifdef APB_FABRIC_TIMEOUT_EN
    // Target 1 never readies; then boundary wait of TO-1 still completes.
    t_waits[1] = 1000;
    do_xfer(32'h8000_0020, 1'b0, 32'h0, 4'h0);
    t_waits[1] = TO - 1;
    do_xfer(32'h8000_0024, 1'b0, 32'h0, 4'h0);
    idle_gap();
`endif

    // Reset during target ACCESS.
    t_waits[1] = 5;
    @(posedge clk); #1;
    core_psel = 1; core_penable = 0; core_pwrite = 1;
    core_paddr = 32'h8000_0010; core_pwdata = 32'h77; core_pwstrb = 4'hF;
    @(posedge clk); #1;
    core_penable = 1;
    @(posedge clk); #1;
    chk("rstmid_psel", 32'(tgt_psel), 2);
    chk("rstmid_penable", 32'(tgt_penable), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rstmid");
    rst = 1'b0;
    core_psel = 0; core_penable = 0;
    t_waits[1] = 1; t_rdata[1] = 32'h0BAD_CAFE;
    do_xfer(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    idle_gap();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++) begin
        t_waits[i] = $urandom_range(0, 3);
        t_rdata[i] = $urandom;
        t_err[i]   = 1'($urandom_range(0, 1));
      end
      kind = $urandom_range(0, 2);
      if (kind == 0)      a = $urandom & 32'h7FFF_FFFF;
      else if (kind == 1) a = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      else                a = 32'h8000_0000 | (32'($urandom_range(1, 32'h7FFFF)) << 12)
                              | ($urandom & 32'h0000_0FFF);
      do_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    idle_gap();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/apb_fabric_n.md
# apb_fabric_n

Parametrised, registered APB interconnect that connects one requester (the core) to `TGT_N` APB completers through a programmable base/mask address map. Each core transfer is captured into registers and re-issued on the selected target port as a fresh SETUP/ACCESS sequence, which cuts the combinational path between core and peripherals. Unmapped addresses return an error response, and an optional watchdog aborts transfers to targets that never assert PREADY. The block sits between the core's APB port and the RAM, UART and future peripherals in the top level.

## Interface
- `TGT_N`, 2: number of target ports.
- `TGT_BASE`, {32'h8000_0000, 32'h0000_0000}: packed `TGT_N*32`; target i base at bits [32i+31:32i].
- `TGT_MASK`, {32'hFFFF_F000, 32'h8000_0000}: packed `TGT_N*32`; address bits compared for target i.
- `TIMEOUT`, 255: ACCESS-phase cycles allowed before abort. Must be at least 1. Used only with the timeout macro.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_i_psel`, `core_i_penable`, `core_i_pwrite` in 1: core APB request controls.
- `core_i_paddr`, `core_i_pwdata` in 32; `core_i_pwstrb` in 4: core request payload.
- `core_i_pready`, `core_i_pslverr` out 1; `core_i_prdata` out 32: core response, all registered.
- `tgt_t_psel` out `TGT_N`: one-hot target select.
- `tgt_t_penable`, `tgt_t_pwrite` out 1: shared target controls.
- `tgt_t_paddr` out 32: offset address (`paddr & ~TGT_MASK[i]`), shared.
- `tgt_t_pwdata` out 32; `tgt_t_pwstrb` out 4: shared write payload.
- `tgt_t_pready`, `tgt_t_pslverr` in `TGT_N`; `tgt_t_prdata` in `TGT_N*32`: per-target responses.

## Operation
- Decode: target i hits when `(core_i_paddr & TGT_MASK[i]) == TGT_BASE[i]`. If several targets hit, the lowest index wins. If no target hits, the access is a miss.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when `core_i_psel & ~core_i_penable`, capture the address, write flag, write data, strobe and decoded index.
  - On a hit, go to SETUP.
  - On a miss, go to RESP with the error response loaded: prdata=0, pslverr=1.
- SETUP: `tgt_t_psel[idx]`=1 and `tgt_t_penable`=0. Go to ACCESS.
- ACCESS: `tgt_t_psel[idx]`=1 and `tgt_t_penable`=1. When `tgt_t_pready[idx]`=1:
  - Register `tgt_t_prdata[idx]` and `tgt_t_pslverr[idx]`.
  - Drop psel and penable in the next cycle.
  - Go to RESP.
- RESP: `core_i_pready`=1 for exactly one cycle, with the registered prdata/pslverr. Go to IDLE.
- `core_i_pready` is 0 in every other state. `core_i_prdata`/`core_i_pslverr` are valid only while pready=1; they hold their last value otherwise.
- Request payload registers stay stable from SETUP through ACCESS. The core must keep its request stable until pready, per APB.
- Write transfers also return the registered target pslverr. prdata on a write is whatever the target drives.
- Non-selected target ports keep psel=0. They still see the shared payload outputs.

## Timing
- Reset: state=IDLE. All outputs are 0: `core_i_pready`, `core_i_prdata`, `core_i_pslverr`, `tgt_t_psel`, `tgt_t_penable`, `tgt_t_paddr`, `tgt_t_pwrite`, `tgt_t_pwdata`, `tgt_t_pwstrb`.
- Reset mid-transfer: the transfer is abandoned immediately and the target psel drops the next cycle. No response is given to the core.
- Hit latency, with the core SETUP at cycle 0:
  - target SETUP at cycle 1;
  - target ACCESS at cycle 2;
  - with a zero-wait target, `core_i_pready` at cycle 3.
  - Each target wait state adds one cycle.
- Miss latency: `core_i_pready` at cycle 1.
- Back-to-back: the core's next SETUP arrives the cycle after RESP and is captured in IDLE. There are no idle bubbles beyond those latencies.

## Configuration
- Macro `APB_FABRIC_TIMEOUT_EN`.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle while pready=0. When it reaches `TIMEOUT`:
  - drop the target psel/penable;
  - load prdata=0, pslverr=1;
  - go to RESP.
- PREADY arriving in the same cycle the count reaches `TIMEOUT` wins, and the target response is used.
- Not defined: no counter is built, and ACCESS waits indefinitely.

## Test plan
- Read 0x0000_0100, target 0 returns 0xDEADBEEF with zero wait -> `tgt_t_psel`=2'b01, `tgt_t_paddr`=0x100; core gets pready at cycle 3, prdata=0xDEADBEEF, pslverr=0.
- Write 0x8000_0004, data 0x55, strobe 4'b0001; target 1 inserts 3 wait states -> `tgt_t_paddr`=0x004, pwdata/pwstrb match; core pready at cycle 6.
- Read 0x9000_0000 (miss) -> no target psel; core pready at cycle 1, prdata=0, pslverr=1.
- Target 0 returns pslverr=1 -> core pslverr=1 in RESP. A second back-to-back read to target 1 completes normally with pslverr=0.
- With `APB_FABRIC_TIMEOUT_EN` and TIMEOUT=4, target 1 never readies -> psel drops after 4 ACCESS cycles; core gets pslverr=1, prdata=0, and the next transfer succeeds.
- Assert rst during a target ACCESS -> all outputs 0 the next cycle, FSM in IDLE; a new read then completes normally.
